seven_seg_scan: RTL and testbench
=================================

# seven_seg_scan

Parametrised N-digit time-multiplexed seven-segment scanner for the 12 MHz HSOSC domain. It drives a shared active-low segment bus and one active-low anode per digit. Digit values are captured once per frame into shadow registers, so a frame never tears. A dead-time blanking interval separates digit slots to suppress ghosting. It also outputs the registered sum of all enabled digits for the LED bar.

## Interface
- NUM_DIGITS, 4, number of digits scanned (≥1)
- DIGIT_CYCLES, 12000, clk cycles per digit slot (1 ms at 12 MHz)
- BLANK_CYCLES, 120, cycles at the start of each slot with all anodes off; must satisfy 0 ≤ BLANK_CYCLES < DIGIT_CYCLES
- SUM_W (localparam), $clog2(15*NUM_DIGITS+1), sum width
- clk  in  1  system clock, 12 MHz from HSOSC
- reset  in  1  asynchronous, active-low reset
- digits  in  4*NUM_DIGITS  hex digit values; digit i is digits[4i+3:4i]
- digit_en  in  NUM_DIGITS  per-digit enable; a disabled digit stays dark
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
- anode  out  NUM_DIGITS  anode drives, active-low, registered, at most one low
- frame_start  out  1  one-cycle pulse when the shadow registers load
- sum  out  SUM_W  sum of enabled shadow digits, registered

## Operation
- **Counters**
  - slot_cnt counts 0..DIGIT_CYCLES-1.
  - On wrap, idx advances 0..NUM_DIGITS-1, then wraps back to 0.
  - Frame period is NUM_DIGITS*DIGIT_CYCLES cycles.
- **Shadow capture**
  - digits and digit_en load into shadow registers on the edge where idx wraps from NUM_DIGITS-1 to 0.
  - They also load on the first clk edge after reset deasserts. A prime flag is set by reset and cleared by that first capture.
  - Input changes between captures have no effect on the outputs.
- **sum**
  - Loads on the same edge as the shadow registers.
  - Value is the unsigned sum of the digits whose digit_en bit is 1. The sum is zero-extended to SUM_W, with no overflow possible.
- **Slot phases**
  - BLANK phase: slot_cnt < BLANK_CYCLES.
  - SHOW phase: otherwise.
  - In BLANK, or when the shadow enable for idx is 0: anode all 1 and seg = 7'b1111111.
  - In SHOW with the digit enabled: anode[idx]=0, all other anodes 1, seg = hex decode of shadow digit idx.
- **Decode** (hex 0–F, active-low)
  - 0 → 1000000
  - 1 → 1111001
  - 8 → 0000000
  - A → 0001000
  - F → 0001110
  - The remaining values use standard hex glyphs. b, c, d are lowercase.
- **frame_start**
  - High for exactly the one cycle after each capture edge.
  - That cycle coincides with the new shadow and sum values first being visible.

## Timing
- **Reset** (asserted, async, immediate):
  - slot_cnt=0, idx=0, shadow digits=0, shadow enables=0, prime=1
  - anode all 1, seg=7'b1111111, frame_start=0, sum=0
- **Output latency**
  - seg and anode are registered from the current slot_cnt, idx and shadow state. They therefore lag the counters by one cycle.
  - With slot_cnt=k at cycle t, the outputs at cycle t+1 reflect phase k.
- **Per-slot timing**
  - Each digit is dark for exactly BLANK_CYCLES cycles.
  - Each digit is lit for exactly DIGIT_CYCLES-BLANK_CYCLES cycles.
  - A one-cycle overlap of two low anodes is forbidden.
- **BLANK_CYCLES=0**: no dark gap. Anode changes directly from one digit to the next on a single edge.
- **NUM_DIGITS=1**
  - idx stays 0.
  - A capture occurs on every slot_cnt wrap.
- **Reset mid-frame**
  - Outputs go dark asynchronously.
  - After release, scanning restarts at digit 0, slot_cnt 0.
  - A fresh capture and a frame_start pulse occur on the first edge.
- **digit_en change mid-frame**: no effect until the next capture.

## Test plan
Use NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2 for all scenarios.
- **Reset values**: hold reset=0 with arbitrary inputs → anode=4'b1111, seg=7'b1111111, sum=0, frame_start=0.
- **First capture**:
  - Stimulus: digits=16'hF81A (digit0=A, digit1=1, digit2=8, digit3=F), digit_en=4'b1111, release reset.
  - Response: frame_start pulses once, sum=34.
  - Per-slot pattern: 2 cycles of anode=1111, then 6 cycles of a single anode low.
  - Lit order and seg values: anode[0]/0001000, anode[1]/1111001, anode[2]/0000000, anode[3]/0001110.
- **Frame timing**: free-run 3 frames → frame_start pulses every 32 cycles exactly. No cycle ever has more than one anode low.
- **Tear-free update**:
  - Stimulus: change digits to 16'h0000 while slot 2 is displayed.
  - Response: slots 2–3 still show 8 and F. The next frame shows 1000000 on all digits, and sum goes to 0 on the same cycle as frame_start.
- **Disabled digit**:
  - Stimulus: digit_en=4'b0101 with digits=16'h3456.
  - Response: slots 1 and 3 stay anode=1111 / seg=1111111 for all 8 cycles. sum=6+4=10.
- **Reset mid-slot**:
  - Stimulus: assert reset in slot 2 at slot_cnt=5, without a clock edge.
  - Response: outputs go dark immediately. After release, scanning restarts at slot 0, with frame_start pulsing on the first edge.

Source files
------------

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed N-digit seven-segment scanner.
//
// Scans NUM_DIGITS digits one slot at a time over a shared active-low segment
// bus. Each slot starts with BLANK_CYCLES of all-anodes-off dead time. Digit
// values and enables are captured once per frame into shadow registers, so a
// frame never tears. The sum of the enabled digits is registered for an LED bar.
//
// Ports:
//   clk         system clock (12 MHz)
//   reset       asynchronous, active-low reset
//   digits      4*NUM_DIGITS hex digit values, digit i = digits[4i+3:4i]
//   digit_en    per-digit enable; a disabled digit stays dark
//   seg         segments {g,f,e,d,c,b,a}, active-low, registered
//   anode       per-digit anode drive, active-low, registered, at most one low
//   frame_start one-cycle pulse in the cycle after the shadow registers load
//   sum         registered sum of the enabled shadow digits
module seven_seg_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 12000,
    parameter int BLANK_CYCLES = 120,
    localparam int SUM_W       = $clog2(15 * NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frame_start,
    output logic [SUM_W-1:0]        sum
);

    localparam int SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_e;

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
    logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
    logic                    prime_q, prime_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_start_q, frame_start_d;
    logic [SUM_W-1:0]        sum_q, sum_d;

    logic                    slot_wrap;
    logic                    idx_wrap;
    logic                    capture;
    logic [3:0]              cur_digit;
    logic                    cur_en;
    logic                    lit;
    phase_e                  phase;
    logic [SUM_W-1:0]        sum_acc;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b0100111;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_wrap = (slot_q == SLOT_W'(DIGIT_CYCLES - 1));
        idx_wrap  = (idx_q == IDX_W'(NUM_DIGITS - 1));
        // The prime flag forces a capture on the first edge after reset so
        // the first frame shows live inputs rather than the reset zeros.
        capture   = prime_q | (slot_wrap & idx_wrap);

        slot_d = slot_wrap ? '0 : slot_q + SLOT_W'(1);
        idx_d  = idx_q;
        if (slot_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + IDX_W'(1);
        end

        sum_acc = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (digit_en[i]) begin
                sum_acc = sum_acc + SUM_W'(digits[4*i +: 4]);
            end
        end

        sh_digits_d   = capture ? digits : sh_digits_q;
        sh_en_d       = capture ? digit_en : sh_en_q;
        sum_d         = capture ? sum_acc : sum_q;
        frame_start_d = capture;
        prime_d       = 1'b0;

        cur_digit = '0;
        cur_en    = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = sh_digits_q[4*i +: 4];
                cur_en    = sh_en_q[i];
            end
        end

        phase = (int'(slot_q) < BLANK_CYCLES) ? PH_BLANK : PH_SHOW;
        lit   = (phase == PH_SHOW) && cur_en;

        seg_d   = lit ? hex_to_seg(cur_digit) : '1;
        anode_d = '1;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (lit && (idx_q == IDX_W'(i))) begin
                anode_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q        <= '0;
            idx_q         <= '0;
            sh_digits_q   <= '0;
            sh_en_q       <= '0;
            prime_q       <= 1'b1;
            seg_q         <= '1;
            anode_q       <= '1;
            frame_start_q <= 1'b0;
            sum_q         <= '0;
        end else begin
            slot_q        <= slot_d;
            idx_q         <= idx_d;
            sh_digits_q   <= sh_digits_d;
            sh_en_q       <= sh_en_d;
            prime_q       <= prime_d;
            seg_q         <= seg_d;
            anode_q       <= anode_d;
            frame_start_q <= frame_start_d;
            sum_q         <= sum_d;
        end
    end

    assign seg         = seg_q;
    assign anode       = anode_q;
    assign frame_start = frame_start_q;
    assign sum         = sum_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan with NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2.
// Stimulus pushes one expected-frame record per capture; the monitor pops a
// record on every frame_start and checks sum, frame period and each cycle of
// anode/seg against the record's hand-computed glyphs.
module tb_seven_seg_scan;

    logic        clk;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  digit_en;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic        frame_start;
    logic [5:0]  sum;

    typedef struct {
        logic [3:0]      en;
        logic [3:0][6:0] segs;
        int              sum;
        bit              ar;
    } rec_t;

    rec_t q[$];
    int   total = 0;
    int   bad   = 0;

    seven_seg_scan #(
        .NUM_DIGITS  (4),
        .DIGIT_CYCLES(8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .digit_en   (digit_en),
        .seg        (seg),
        .anode      (anode),
        .frame_start(frame_start),
        .sum        (sum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] exp_out(input rec_t r, input int p);
        int d;
        int s;
        logic [3:0] a;
        d = p / 8;
        s = p % 8;
        a = 4'b1111;
        if (s < 2 || !r.en[d]) return {4'b1111, 7'b1111111};
        a[d] = 1'b0;
        return {a, r.segs[d]};
    endfunction

    task automatic issue(input logic [15:0] d, input logic [3:0] e,
                         input logic [27:0] s, input int sm, input bit ar);
        rec_t r;
        digits   = d;
        digit_en = e;
        r.en     = e;
        r.segs   = s;
        r.sum    = sm;
        r.ar     = ar;
        q.push_back(r);
    endtask

    task automatic wait_frame();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (frame_start) found = 1'b1;
        end
        if (!found) begin
            total++;
            bad++;
            $display("FAIL frame_wait actual=no_pulse required=pulse within 40 cycles");
        end
    endtask

    // Monitor
    rec_t mon_cur;
    rec_t mon_new;
    bit   mon_ok;
    bit   prev_low;
    int   pos;

    initial begin
        mon_ok   = 1'b0;
        prev_low = 1'b1;
        pos      = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("reset_outputs", {frame_start, sum, anode, seg},
                      {1'b0, 6'd0, 4'b1111, 7'b1111111});
                mon_ok   = 1'b0;
                prev_low = 1'b1;
            end else begin
                if (prev_low) check("first_edge_capture", frame_start, 1'b1);
                if (frame_start) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame actual=pulse required=none");
                        mon_ok = 1'b0;
                    end else begin
                        mon_new = q.pop_front();
                        check("sum", sum, mon_new.sum);
                        check("capture_kind", prev_low, mon_new.ar);
                        if (mon_new.ar) begin
                            mon_cur = mon_new;
                            mon_ok  = 1'b1;
                            check("scan_out", {anode, seg}, exp_out(mon_cur, 0));
                            pos = 1;
                        end else begin
                            if (mon_ok) begin
                                check("frame_period", pos, 31);
                                check("scan_out", {anode, seg}, exp_out(mon_cur, pos));
                            end
                            mon_cur = mon_new;
                            mon_ok  = 1'b1;
                            pos     = 0;
                        end
                    end
                end else if (mon_ok) begin
                    if (pos > 31) begin
                        total++;
                        bad++;
                        $display("FAIL frame_period actual=missing_pulse required=pulse at pos 31");
                        mon_ok = 1'b0;
                    end else begin
                        check("scan_out", {anode, seg}, exp_out(mon_cur, pos));
                        pos++;
                    end
                end
                prev_low = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [27:0] SEG_F81A = {7'b0001110, 7'b0000000, 7'b1111001, 7'b0001000};
    localparam logic [27:0] SEG_0000 = {4{7'b1000000}};
    localparam logic [27:0] SEG_3456 = {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010};
    localparam logic [27:0] SEG_EDCB = {7'b0000110, 7'b0100001, 7'b0100111, 7'b0000011};
    localparam logic [27:0] SEG_9720 = {7'b0010000, 7'b1111000, 7'b0100100, 7'b1000000};

    initial begin
        reset    = 1'b0;
        digits   = 16'h1234;
        digit_en = 4'b1111;
        repeat (3) @(negedge clk);

        // First capture after reset, then three free-running frames.
        issue(16'hF81A, 4'b1111, SEG_F81A, 34, 1'b1);
        @(negedge clk);
        #1 reset = 1'b1;
        wait_frame();
        for (int f = 0; f < 3; f++) begin
            issue(16'hF81A, 4'b1111, SEG_F81A, 34, 1'b0);
            wait_frame();
        end

        // Change digits while slot 2 is lit; current frame must not tear.
        repeat (20) @(negedge clk);
        issue(16'h0000, 4'b1111, SEG_0000, 0, 1'b0);
        wait_frame();

        // Disabled digits 1 and 3.
        issue(16'h3456, 4'b0101, SEG_3456, 10, 1'b0);
        wait_frame();
        // Mid-frame input change must not reach the outputs.
        repeat (10) @(negedge clk);
        digits   = 16'hFFFF;
        digit_en = 4'b1111;
        repeat (10) @(negedge clk);
        issue(16'hEDCB, 4'b1010, SEG_EDCB, 26, 1'b0);
        wait_frame();
        issue(16'h9720, 4'b1111, SEG_9720, 18, 1'b0);
        wait_frame();

        // Reset asserted in slot 2 at slot_cnt 5, between clock edges.
        repeat (21) @(posedge clk);
        #2;
        check("pre_reset_lit", {anode, seg}, {4'b1011, 7'b1111000});
        reset = 1'b0;
        #1;
        check("async_reset_dark", {frame_start, sum, anode, seg},
              {1'b0, 6'd0, 4'b1111, 7'b1111111});
        repeat (3) @(negedge clk);
        issue(16'hF81A, 4'b1111, SEG_F81A, 34, 1'b1);
        @(negedge clk);
        #1 reset = 1'b1;
        wait_frame();
        repeat (28) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
